// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage data-bus access unit: FSM state
// encoding, MEM/WB load selection and the default bus timeout.
package mips_pkg;

   // Default limit on ACCESS cycles spent waiting for mem_ack.
   localparam int TIMEOUT_DEFAULT = 255;

   // Width of the ACCESS-cycle counter; it saturates, never wraps.
   localparam int CNT_W = 8;

   // Access FSM states.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } mau_state_e;

   // What the MEM/WB register loads at the next edge.
   typedef enum logic [1:0] {
      WB_BUBBLE   = 2'd0,  // all zeros
      WB_PASS     = 2'd1,  // EX/MEM controls and ALU result, ReadData 0
      WB_ADDR_ERR = 2'd2,  // as WB_PASS but the register write is killed
      WB_MEM      = 2'd3   // EX/MEM controls plus captured bus data
   } wb_sel_e;

   // Word accesses only: the two address LSBs must be zero.
   function automatic logic is_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the MEM stage and data memory.
//
// Handshake: the master raises mem_req together with mem_addr, mem_we and
// mem_wdata and holds all four constant until the slave answers. The slave
// completes the transfer by pulsing mem_ack for exactly one cycle; read data
// on mem_rdata is valid in that same cycle. The master drops mem_req on the
// edge that samples mem_ack. mem_ack seen while no request is outstanding
// carries no meaning and is ignored by the master.
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles and flags the cycle on which the wait limit is
// reached. The count restarts from zero whenever clear is high and holds at
// its maximum instead of wrapping.
module mem_timeout_counter
   import mips_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic hit
);

   // Value of the count during the LIMIT-th enabled cycle.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_q;

   // Count enabled cycles; clear takes priority, saturate at all-ones.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign hit = enable && (count_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage with a handshaked data-bus port. Loads and stores are
// issued on the bus and the upstream pipeline is stalled until the bus
// answers or the wait limit expires; the result is then written into the
// MEM/WB register. Misaligned addresses never reach the bus.
module mem_access_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   // EX/MEM register contents
   input  logic                      RegWrite_in,
   input  logic                      MemRead_in,
   input  logic                      MemWrite_in,
   input  logic [1:0]                MemtoReg_in,
   input  logic [31:0]               PC_in,
   input  logic [31:0]               ALUout_in,
   input  logic [31:0]               DataBusB_in,
   input  logic [4:0]                WriteAddr_in,
   // data bus
   mem_access_unit_if.master         bus,
   // pipeline hold for PC, IF/ID, ID/EX and EX/MEM
   output logic                      stall,
   // MEM/WB register
   output logic                      RegWrite_out,
   output logic [1:0]                MemtoReg_out,
   output logic [4:0]                WriteAddr_out,
   output logic [31:0]               PC_out,
   output logic [31:0]               ALUout_out,
   output logic [31:0]               ReadData_out,
   // one-cycle error pulses
   output logic                      addr_err,
   output logic                      bus_err,
   // current FSM state
   output mau_state_e                state_dbg
);

   mau_state_e state_q;
   mau_state_e state_d;
   wb_sel_e    wb_sel;

   logic access_req;
   logic aligned;
   logic start_access;
   logic misalign;
   logic ack_ok;
   logic timeout;
   logic to_hit;

   logic [31:0] rdata_q;      // data captured at the end of ACCESS
   logic        timed_out_q;  // last access ended without an ack

   // A memory instruction in EX/MEM that clear has not squashed.
   assign access_req   = (MemRead_in | MemWrite_in) & ~clear;
   assign aligned      = is_aligned(ALUout_in[1:0]);
   assign start_access = (state_q == S_IDLE) && access_req && aligned;
   assign misalign     = (state_q == S_IDLE) && access_req && !aligned;
   // An ack on the limit cycle still counts as a successful transfer.
   assign ack_ok       = (state_q == S_ACCESS) && bus.mem_ack;
   assign timeout      = (state_q == S_ACCESS) && !bus.mem_ack && to_hit;

   assign state_dbg = state_q;

   // Wait counter: runs only in ACCESS, so it is zero on every entry.
   mem_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .enable (state_q == S_ACCESS),
      .clear  (state_q != S_ACCESS),
      .hit    (to_hit)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; DONE always returns to IDLE without a new access.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start_access)      state_d = S_ACCESS;
         S_ACCESS: if (ack_ok || timeout) state_d = S_DONE;
         S_DONE:                          state_d = S_IDLE;
         default:                         state_d = S_IDLE;
      endcase
   end

   // FSM outputs: pipeline stall and the MEM/WB load selection.
   always_comb begin
      stall  = 1'b0;
      wb_sel = WB_BUBBLE;
      unique case (state_q)
         S_IDLE: begin
            stall = start_access;
            // The memory instruction writes back from DONE, so it leaves a
            // bubble behind while it is on the bus.
            if (clear || start_access) wb_sel = WB_BUBBLE;
            else if (misalign)         wb_sel = WB_ADDR_ERR;
            else                       wb_sel = WB_PASS;
         end
         S_ACCESS: begin
            // clear is deliberately ignored while the bus is busy.
            stall  = 1'b1;
            wb_sel = WB_BUBBLE;
         end
         S_DONE: begin
            wb_sel = clear ? WB_BUBBLE : WB_MEM;
         end
         default: begin
            stall  = 1'b0;
            wb_sel = WB_BUBBLE;
         end
      endcase
      // Keep the pipeline free while reset is held.
      if (reset) stall = 1'b0;
   end

   // Bus request: launched from IDLE, held stable until ack or timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else if (start_access) begin
         bus.mem_req   <= 1'b1;
         bus.mem_we    <= MemWrite_in;
         bus.mem_addr  <= ALUout_in;
         bus.mem_wdata <= DataBusB_in;
      end else if (ack_ok || timeout) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end
   end

   // Capture read data (zero for stores or timeouts) and the timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q     <= '0;
         timed_out_q <= 1'b0;
      end else if (start_access) begin
         rdata_q     <= '0;
         timed_out_q <= 1'b0;
      end else if (ack_ok) begin
         rdata_q     <= bus.mem_we ? 32'h0 : bus.mem_rdata;
         timed_out_q <= 1'b0;
      end else if (timeout) begin
         rdata_q     <= '0;
         timed_out_q <= 1'b1;
      end
   end

   // Error pulses, each high for the single cycle after the event.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_err <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         addr_err <= misalign;
         bus_err  <= timeout;
      end
   end

   // MEM/WB register.
   always_ff @(posedge clk) begin
      if (reset) begin
         RegWrite_out  <= 1'b0;
         MemtoReg_out  <= '0;
         WriteAddr_out <= '0;
         PC_out        <= '0;
         ALUout_out    <= '0;
         ReadData_out  <= '0;
      end else begin
         unique case (wb_sel)
            WB_PASS: begin
               RegWrite_out  <= RegWrite_in;
               MemtoReg_out  <= MemtoReg_in;
               WriteAddr_out <= WriteAddr_in;
               PC_out        <= PC_in;
               ALUout_out    <= ALUout_in;
               ReadData_out  <= '0;
            end
            WB_ADDR_ERR: begin
               RegWrite_out  <= 1'b0;
               MemtoReg_out  <= MemtoReg_in;
               WriteAddr_out <= WriteAddr_in;
               PC_out        <= PC_in;
               ALUout_out    <= ALUout_in;
               ReadData_out  <= '0;
            end
            WB_MEM: begin
               RegWrite_out  <= RegWrite_in & ~timed_out_q;
               MemtoReg_out  <= MemtoReg_in;
               WriteAddr_out <= WriteAddr_in;
               PC_out        <= PC_in;
               ALUout_out    <= ALUout_in;
               ReadData_out  <= rdata_q;
            end
            default: begin
               RegWrite_out  <= 1'b0;
               MemtoReg_out  <= '0;
               WriteAddr_out <= '0;
               PC_out        <= '0;
               ALUout_out    <= '0;
               ReadData_out  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a four-cycle bus wait limit.
module tb_mem_access_unit;
   import mips_pkg::*;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        RegWrite_in, MemRead_in, MemWrite_in;
   logic [1:0]  MemtoReg_in;
   logic [31:0] PC_in, ALUout_in, DataBusB_in;
   logic [4:0]  WriteAddr_in;
   logic        stall;
   logic        RegWrite_out;
   logic [1:0]  MemtoReg_out;
   logic [4:0]  WriteAddr_out;
   logic [31:0] PC_out, ALUout_out, ReadData_out;
   logic        addr_err, bus_err;
   mau_state_e  state_dbg;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   mem_access_unit_if bus ();

   mem_access_unit #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .clear         (clear),
      .RegWrite_in   (RegWrite_in),
      .MemRead_in    (MemRead_in),
      .MemWrite_in   (MemWrite_in),
      .MemtoReg_in   (MemtoReg_in),
      .PC_in         (PC_in),
      .ALUout_in     (ALUout_in),
      .DataBusB_in   (DataBusB_in),
      .WriteAddr_in  (WriteAddr_in),
      .bus           (bus),
      .stall         (stall),
      .RegWrite_out  (RegWrite_out),
      .MemtoReg_out  (MemtoReg_out),
      .WriteAddr_out (WriteAddr_out),
      .PC_out        (PC_out),
      .ALUout_out    (ALUout_out),
      .ReadData_out  (ReadData_out),
      .addr_err      (addr_err),
      .bus_err       (bus_err),
      .state_dbg     (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_nop();
      RegWrite_in  = 1'b0;
      MemRead_in   = 1'b0;
      MemWrite_in  = 1'b0;
      MemtoReg_in  = 2'b00;
      PC_in        = '0;
      ALUout_in    = '0;
      DataBusB_in  = '0;
      WriteAddr_in = '0;
   endtask

   task automatic drive_instr(input logic rw, input logic rd, input logic wr, input logic [1:0] m2r,
                              input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] db,
                              input logic [4:0] wa);
      RegWrite_in  = rw;
      MemRead_in   = rd;
      MemWrite_in  = wr;
      MemtoReg_in  = m2r;
      PC_in        = pc;
      ALUout_in    = alu;
      DataBusB_in  = db;
      WriteAddr_in = wa;
   endtask

   // Bus responder: runs from the request cycle until stall falls, acking
   // on the given request cycle (negative = never). Returns in DONE.
   task automatic run_access(input int ack_after, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input bit clr_in_acc,
                             output int stall_cnt, output int req_cnt);
      bit ended;
      stall_cnt = 0;
      req_cnt   = 0;
      ended     = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         #1;
         if (stall !== 1'b1) begin
            ended = 1'b1;
            break;
         end
         stall_cnt++;
         if (bus.mem_req === 1'b1) begin
            check("req_addr_stable", bus.mem_addr, exp_addr);
            clear = clr_in_acc;
            if (req_cnt == ack_after) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = rdata;
            end else begin
               bus.mem_ack   = 1'b0;
               bus.mem_rdata = 32'h1111_2222;
            end
            req_cnt++;
         end else begin
            clear       = 1'b0;
            bus.mem_ack = 1'b0;
         end
         tick();
      end
      bus.mem_ack = 1'b0;
      clear       = 1'b0;
      if (!ended) check("access_bound", 32'd0, 32'd1);
   endtask

   int sc, rc;

   initial begin
      reset         = 1'b1;
      clear         = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      drive_nop();
      tick();
      tick();

      // reset state
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_regwrite", 32'(RegWrite_out), 32'd0);
      check("rst_aluout", ALUout_out, 32'd0);
      check("rst_state", 32'(state_dbg), 32'(S_IDLE));
      reset = 1'b0;

      // ALU op passes in one cycle; a stray ack in IDLE is ignored
      drive_instr(1'b1, 1'b0, 1'b0, 2'b00, 32'h40, 32'h1234, 32'h0, 5'd7);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h9999_9999;
      #1;
      check("alu_stall", 32'(stall), 32'd0);
      tick();
      bus.mem_ack = 1'b0;
      check("alu_aluout", ALUout_out, 32'h1234);
      check("alu_regwrite", 32'(RegWrite_out), 32'd1);
      check("alu_waddr", 32'(WriteAddr_out), 32'd7);
      check("alu_pc", PC_out, 32'h40);
      check("alu_rdata", ReadData_out, 32'd0);
      check("alu_mem_req", 32'(bus.mem_req), 32'd0);
      check("alu_stall2", 32'(stall), 32'd0);

      // load, ack on the fourth request cycle (also the limit cycle)
      drive_instr(1'b1, 1'b1, 1'b0, 2'b01, 32'h44, 32'h100, 32'h0, 5'd9);
      exp_q.push_back(32'hDEAD_BEEF);
      run_access(3, 32'hDEAD_BEEF, 32'h100, 1'b0, sc, rc);
      check("ld_stall_cycles", 32'(sc), 32'd5);
      check("ld_req_cycles", 32'(rc), 32'd4);
      check("ld_done_req", 32'(bus.mem_req), 32'd0);
      check("ld_done_buserr", 32'(bus_err), 32'd0);
      check("ld_done_state", 32'(state_dbg), 32'(S_DONE));
      tick();
      drive_nop();
      check("ld_rdata", ReadData_out, exp_q.pop_front());
      check("ld_regwrite", 32'(RegWrite_out), 32'd1);
      check("ld_waddr", 32'(WriteAddr_out), 32'd9);
      check("ld_m2r", 32'(MemtoReg_out), 32'd1);
      check("ld_state", 32'(state_dbg), 32'(S_IDLE));

      // store with read also set: write wins, immediate ack, no read data
      drive_instr(1'b0, 1'b1, 1'b1, 2'b00, 32'h48, 32'h204, 32'hA5A5_A5A5, 5'd0);
      #1;
      check("st_stall_comb", 32'(stall), 32'd1);
      tick();
      check("st_mem_req", 32'(bus.mem_req), 32'd1);
      check("st_mem_we", 32'(bus.mem_we), 32'd1);
      check("st_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
      check("st_mem_addr", bus.mem_addr, 32'h204);
      run_access(0, 32'hFFFF_FFFF, 32'h204, 1'b0, sc, rc);
      check("st_stall_cycles", 32'(sc), 32'd1);
      tick();
      drive_nop();
      check("st_rdata", ReadData_out, 32'd0);
      check("st_aluout", ALUout_out, 32'h204);

      // misaligned load
      drive_instr(1'b1, 1'b1, 1'b0, 2'b01, 32'h4C, 32'h102, 32'h0, 5'd3);
      #1;
      check("mis_stall", 32'(stall), 32'd0);
      tick();
      drive_nop();
      check("mis_addr_err", 32'(addr_err), 32'd1);
      check("mis_mem_req", 32'(bus.mem_req), 32'd0);
      check("mis_regwrite", 32'(RegWrite_out), 32'd0);
      check("mis_aluout", ALUout_out, 32'h102);
      tick();
      check("mis_addr_err_pulse", 32'(addr_err), 32'd0);

      // timeout: no ack within four ACCESS cycles
      drive_instr(1'b1, 1'b1, 1'b0, 2'b01, 32'h50, 32'h300, 32'h0, 5'd4);
      run_access(-1, 32'h0, 32'h300, 1'b0, sc, rc);
      check("to_req_cycles", 32'(rc), 32'd4);
      check("to_stall_cycles", 32'(sc), 32'd5);
      check("to_bus_err", 32'(bus_err), 32'd1);
      check("to_mem_req", 32'(bus.mem_req), 32'd0);
      tick();
      drive_nop();
      check("to_bus_err_pulse", 32'(bus_err), 32'd0);
      check("to_regwrite", 32'(RegWrite_out), 32'd0);
      check("to_rdata", ReadData_out, 32'd0);
      check("to_waddr", 32'(WriteAddr_out), 32'd4);

      // clear in IDLE squashes an aligned load into a bubble
      drive_instr(1'b1, 1'b1, 1'b0, 2'b01, 32'h54, 32'h55C, 32'h0, 5'd6);
      clear = 1'b1;
      #1;
      check("clr_stall", 32'(stall), 32'd0);
      tick();
      clear = 1'b0;
      drive_nop();
      check("clr_regwrite", 32'(RegWrite_out), 32'd0);
      check("clr_aluout", ALUout_out, 32'd0);
      check("clr_pc", PC_out, 32'd0);
      check("clr_mem_req", 32'(bus.mem_req), 32'd0);

      // clear while on the bus has no effect
      drive_instr(1'b1, 1'b1, 1'b0, 2'b01, 32'h58, 32'h180, 32'h0, 5'd11);
      exp_q.push_back(32'h0BAD_F00D);
      run_access(1, 32'h0BAD_F00D, 32'h180, 1'b1, sc, rc);
      check("clra_stall_cycles", 32'(sc), 32'd3);
      tick();
      drive_nop();
      check("clra_rdata", ReadData_out, exp_q.pop_front());
      check("clra_regwrite", 32'(RegWrite_out), 32'd1);

      // reset mid-ACCESS, then a late ack
      drive_instr(1'b1, 1'b1, 1'b0, 2'b01, 32'h5C, 32'h200, 32'h0, 5'd12);
      tick();
      check("rsta_mem_req", 32'(bus.mem_req), 32'd1);
      reset         = 1'b1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h7777_7777;
      tick();
      check("rsta_mem_req0", 32'(bus.mem_req), 32'd0);
      check("rsta_mem_addr0", bus.mem_addr, 32'd0);
      check("rsta_stall0", 32'(stall), 32'd0);
      check("rsta_state", 32'(state_dbg), 32'(S_IDLE));
      check("rsta_rdata0", ReadData_out, 32'd0);
      reset = 1'b0;
      drive_nop();
      tick();
      bus.mem_ack = 1'b0;
      check("rsta_late_ack_state", 32'(state_dbg), 32'(S_IDLE));
      check("rsta_late_ack_rdata", ReadData_out, 32'd0);
      check("rsta_late_ack_req", 32'(bus.mem_req), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
